// File: rtl/alu_pkg.sv
// Shared opcode/state encodings and a latency helper for the sequential ALU.
// Latency helper lets users predict when alu_done will fire for a given request.
package alu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9,
        ALU_MUL  = 4'd10
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE,
        EXEC,
        DONE
    } alu_state_e;

    function automatic logic is_shift_op(input logic [3:0] op);
        return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
    endfunction

    // Cycles from the accepting edge to the edge that raises alu_done.
    function automatic int unsigned alu_latency(input logic [3:0] op, input int unsigned shamt,
                                                input int unsigned xlen, input int unsigned shift_step);
        if (is_shift_op(op)) begin
            return 1 + (shamt + shift_step - 1) / shift_step;
        end
        if (op == ALU_MUL) begin
            return 1 + xlen;
        end
        return 1;
    endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/response bundle between the control unit (master) and the ALU (slave).
interface alu_seq_if #(
    parameter int unsigned XLEN = 32
);
    logic            alu_req;
    logic [3:0]      alu_operation;
    logic [XLEN-1:0] alu_op1;
    logic [XLEN-1:0] alu_op2;
    logic            alu_busy;
    logic            alu_done;
    logic [XLEN-1:0] alu_res;
    logic            alu_zero;
    logic            alu_err;

    modport master (
        output alu_req, alu_operation, alu_op1, alu_op2,
        input  alu_busy, alu_done, alu_res, alu_zero, alu_err
    );

    modport slave (
        input  alu_req, alu_operation, alu_op1, alu_op2,
        output alu_busy, alu_done, alu_res, alu_zero, alu_err
    );
endinterface

// File: rtl/alu_iter_unit.sv
// Iterative shifter (SHIFT_STEP bits per cycle) and shift-add multiplier (one bit per cycle).
module alu_iter_unit
    import alu_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned SHIFT_STEP = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_i,
    input  logic [3:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    output logic            finish_o,
    output logic [XLEN-1:0] result_o
);
    localparam int unsigned SW = $clog2(XLEN);
    localparam int unsigned CW = SW + 1;

    logic [3:0]      op_q, op_d;
    logic [XLEN-1:0] val_q, val_d;
    logic [XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0] mpl_q, mpl_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [CW-1:0]   step_amt;

    // For shifts cnt_q is the remaining shift distance; the final step may be partial.
    assign step_amt = (cnt_q < CW'(SHIFT_STEP)) ? cnt_q : CW'(SHIFT_STEP);

    always_comb begin
        op_d  = op_q;
        val_d = val_q;
        acc_d = acc_q;
        mpl_d = mpl_q;
        cnt_d = cnt_q;
        if (start_i) begin
            op_d  = op_i;
            val_d = a_i;
            acc_d = '0;
            mpl_d = b_i;
            cnt_d = (op_i == ALU_MUL) ? CW'(XLEN) : {1'b0, b_i[SW-1:0]};
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - step_amt;
            case (op_q)
                ALU_SLL: val_d = val_q << step_amt;
                ALU_SRL: val_d = val_q >> step_amt;
                ALU_SRA: val_d = $unsigned($signed(val_q) >>> step_amt);
                ALU_MUL: begin
                    if (mpl_q[0]) begin
                        acc_d = acc_q + val_q;
                    end
                    val_d = val_q << 1;
                    mpl_d = mpl_q >> 1;
                    cnt_d = cnt_q - CW'(1);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q  <= '0;
            val_q <= '0;
            acc_q <= '0;
            mpl_q <= '0;
            cnt_q <= '0;
        end else begin
            op_q  <= op_d;
            val_q <= val_d;
            acc_q <= acc_d;
            mpl_q <= mpl_d;
            cnt_q <= cnt_d;
        end
    end

    assign finish_o = (cnt_q == '0);
    assign result_o = (op_q == ALU_MUL) ? acc_q : val_q;
endmodule

// File: rtl/alu_seq.sv
// Multi-cycle XLEN-bit ALU with req/done handshake; single-cycle ops here, shifts/MUL in alu_iter_unit.
module alu_seq
    import alu_pkg::*;
#(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned SHIFT_STEP = 1,
    parameter bit          MUL_EN     = 1'b1
) (
    input  logic      clk,
    input  logic      rst,
    alu_seq_if.slave  bus
);
    alu_state_e      state_q;
    logic [3:0]      op_q;
    logic [XLEN-1:0] a_q, b_q;
    logic            iter_q;
    logic            busy_q, done_q, err_q, zero_q;
    logic [XLEN-1:0] res_q;

    logic [XLEN-1:0] res_d;
    logic            err_d;
    logic            accept;
    logic            new_iter;
    logic            iter_fin;
    logic [XLEN-1:0] iter_res;

    assign accept   = bus.alu_req && (state_q != EXEC);
    assign new_iter = is_shift_op(bus.alu_operation) || (MUL_EN && (bus.alu_operation == ALU_MUL));

    alu_iter_unit #(
        .XLEN       (XLEN),
        .SHIFT_STEP (SHIFT_STEP)
    ) u_iter (
        .clk      (clk),
        .rst_n    (rst),
        .start_i  (accept && new_iter),
        .op_i     (bus.alu_operation),
        .a_i      (bus.alu_op1),
        .b_i      (bus.alu_op2),
        .finish_o (iter_fin),
        .result_o (iter_res)
    );

    always_comb begin
        res_d = '0;
        err_d = 1'b0;
        case (op_q)
            ALU_ADD:  res_d = a_q + b_q;
            ALU_SUB:  res_d = a_q - b_q;
            ALU_AND:  res_d = a_q & b_q;
            ALU_OR:   res_d = a_q | b_q;
            ALU_XOR:  res_d = a_q ^ b_q;
            ALU_SLT:  res_d = {{(XLEN-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
            ALU_SLTU: res_d = {{(XLEN-1){1'b0}}, (a_q < b_q)};
            ALU_SLL, ALU_SRL, ALU_SRA: res_d = iter_res;
            ALU_MUL: begin
                if (MUL_EN) begin
                    res_d = iter_res;
                end else begin
                    err_d = 1'b1;
                end
            end
            default:  err_d = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            iter_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            res_q   <= '0;
            zero_q  <= 1'b1;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            case (state_q)
                IDLE, DONE: begin
                    state_q <= IDLE;
                    if (accept) begin
                        state_q <= EXEC;
                        busy_q  <= 1'b1;
                        op_q    <= bus.alu_operation;
                        a_q     <= bus.alu_op1;
                        b_q     <= bus.alu_op2;
                        iter_q  <= new_iter;
                    end
                end
                EXEC: begin
                    if (!iter_q || iter_fin) begin
                        state_q <= DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        err_q   <= err_d;
                        res_q   <= res_d;
                        zero_q  <= (res_d == '0);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.alu_busy = busy_q;
    assign bus.alu_done = done_q;
    assign bus.alu_err  = err_q;
    assign bus.alu_res  = res_q;
    assign bus.alu_zero = zero_q;
endmodule
